// File: rtl/rf_write_arbiter_if.sv
// Bundle of the writeback, long-latency and register-file write signals
// around rf_write_arbiter. "slave" is the arbiter's view, "master" is the
// view of whatever drives the pipeline and long-latency sides.
interface rf_write_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int DEPTH  = 2
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    // Pipeline writeback side
    logic              wb_wback;
    logic [REG_W-1:0]  wb_wreg;
    logic [DATA_W-1:0] wb_wdata;
    logic              wb_stall;

    // Long-latency side
    logic              ll_valid;
    logic              ll_ready;
    logic [REG_W-1:0]  ll_wreg;
    logic [DATA_W-1:0] ll_wdata;

    // Register-file write port and occupancy
    logic              rf_we;
    logic [REG_W-1:0]  rf_wreg;
    logic [DATA_W-1:0] rf_wdata;
    logic [CNT_W-1:0]  ll_pending;

    modport slave (
        input  wb_wback, wb_wreg, wb_wdata,
        output wb_stall,
        input  ll_valid, ll_wreg, ll_wdata,
        output ll_ready,
        output rf_we, rf_wreg, rf_wdata, ll_pending
    );

    modport master (
        output wb_wback, wb_wreg, wb_wdata,
        input  wb_stall,
        output ll_valid, ll_wreg, ll_wdata,
        input  ll_ready,
        input  rf_we, rf_wreg, rf_wdata, ll_pending
    );
endinterface

// File: rtl/rf_write_arbiter.sv
// Register-file write port arbiter. Pipeline writebacks normally own the
// port; long-latency results wait in a small FIFO and take idle slots, or
// are forced through (stalling writeback one cycle) once the FIFO head has
// waited MAX_WAIT cycles.
//
// Handshakes:
//   ll side: a transfer happens on any rising edge where ll_valid && ll_ready.
//     The producer keeps ll_valid and its payload stable until that edge;
//     ll_ready does not depend on ll_valid. A transfer to x0 is consumed
//     but never stored.
//   wb side: a request with wb_wback && wb_wreg != 0 is consumed on the edge
//     where wb_stall is low; while wb_stall is high the pipeline holds its
//     wb_* inputs unchanged for the next cycle.
module rf_write_arbiter #(
    parameter int DATA_W   = 32,
    parameter int REG_W    = 5,
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    rf_write_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int AGE_W = $clog2(MAX_WAIT + 1);

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(MAX_WAIT);

    // FIFO storage and bookkeeping
    logic [REG_W-1:0]  fifo_reg  [DEPTH];
    logic [DATA_W-1:0] fifo_data [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [AGE_W-1:0]  age_q;

    // Registered write port
    logic              rf_we_q;
    logic [REG_W-1:0]  rf_wreg_q;
    logic [DATA_W-1:0] rf_wdata_q;

    // Per-cycle decision
    logic wb_eff;
    logic head_valid;
    logic ll_ready_c;
    logic push;
    logic grant_ll;
    logic grant_wb;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // Grant decision from current state: the head wins on an idle pipeline
    // slot or once it has waited long enough; otherwise writeback wins.
    always_comb begin
        wb_eff     = bus.wb_wback && (bus.wb_wreg != '0);
        head_valid = (count_q != '0);
        ll_ready_c = rst && (count_q < FULL_CNT);
        push       = bus.ll_valid && ll_ready_c && (bus.ll_wreg != '0);
        grant_ll   = head_valid && ((age_q >= AGE_MAX) || !wb_eff);
        grant_wb   = !grant_ll && wb_eff;
    end

    assign bus.ll_ready   = ll_ready_c;
    assign bus.wb_stall   = rst && grant_ll && wb_eff;
    assign bus.rf_we      = rf_we_q;
    assign bus.rf_wreg    = rf_wreg_q;
    assign bus.rf_wdata   = rf_wdata_q;
    assign bus.ll_pending = count_q;

    // FIFO payload storage; contents are don't-care until counted valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_reg[wr_ptr_q]  <= bus.ll_wreg;
            fifo_data[wr_ptr_q] <= bus.ll_wdata;
        end
    end

    // FIFO pointers and occupancy; a same-cycle push and pop keeps the count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push)     wr_ptr_q <= next_ptr(wr_ptr_q);
            if (grant_ll) rd_ptr_q <= next_ptr(rd_ptr_q);
            count_q <= count_q + CNT_W'(push) - CNT_W'(grant_ll);
        end
    end

    // Age of the current head: restarts whenever the head leaves or the
    // FIFO is empty, otherwise counts ungranted cycles up to MAX_WAIT.
    always_ff @(posedge clk) begin
        if (!rst) begin
            age_q <= '0;
        end else if (grant_ll || !head_valid) begin
            age_q <= '0;
        end else if (age_q != AGE_MAX) begin
            age_q <= age_q + AGE_W'(1);
        end
    end

    // Register-file write port; index and data hold when nothing is granted.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rf_we_q    <= 1'b0;
            rf_wreg_q  <= '0;
            rf_wdata_q <= '0;
        end else begin
            rf_we_q <= grant_ll || grant_wb;
            if (grant_ll) begin
                rf_wreg_q  <= fifo_reg[rd_ptr_q];
                rf_wdata_q <= fifo_data[rd_ptr_q];
            end else if (grant_wb) begin
                rf_wreg_q  <= bus.wb_wreg;
                rf_wdata_q <= bus.wb_wdata;
            end
        end
    end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed scenarios followed by
// random traffic, checked against a queue-based reference model.
module tb_rf_write_arbiter;
  localparam int DATA_W   = 32;
  localparam int REG_W    = 5;
  localparam int DEPTH    = 2;
  localparam int MAX_WAIT = 4;
  localparam int PAIR_W   = REG_W + DATA_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rf_write_arbiter_if #(.DATA_W(DATA_W), .REG_W(REG_W), .DEPTH(DEPTH)) bus();

  rf_write_arbiter #(
    .DATA_W(DATA_W), .REG_W(REG_W), .DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [PAIR_W-1:0] exp_q[$];     // expected register-file writes, in order
  logic [PAIR_W-1:0] m_fifo[$];    // model of buffered long-latency results
  int head_wait = 0;               // cycles the model's head has waited
  bit last_stall = 1'b0;
  bit last_acc   = 1'b0;
  bit reset_edge = 1'b1;
  logic [PAIR_W-1:0] last_exp = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Evaluated mid-cycle with the inputs stable: checks the combinational
  // outputs and predicts which write the coming edge produces.
  always @(negedge clk) begin : model
    int sz;
    bit eff, rdy, gll, stall;
    sz    = m_fifo.size();
    eff   = bus.wb_wback && (bus.wb_wreg != '0);
    rdy   = rst && (sz < DEPTH);
    stall = 1'b0;
    check("ll_pending", 64'(bus.ll_pending), 64'(sz));
    check("ll_ready", 64'(bus.ll_ready), 64'(rdy));
    if (!rst) begin
      m_fifo.delete();
      head_wait = 0;
    end else begin
      gll   = (sz > 0) && ((head_wait >= MAX_WAIT) || !eff);
      stall = gll && eff;
      if (gll) begin
        exp_q.push_back(m_fifo.pop_front());
        head_wait = 0;
      end else begin
        if (eff) exp_q.push_back({bus.wb_wreg, bus.wb_wdata});
        if (sz > 0) head_wait++;
      end
      if (bus.ll_valid && rdy && (bus.ll_wreg != '0))
        m_fifo.push_back({bus.ll_wreg, bus.ll_wdata});
    end
    check("wb_stall", 64'(bus.wb_stall), 64'(stall));
    last_stall = stall;
    last_acc   = bus.ll_valid && rdy;
    reset_edge = !rst;
  end

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (reset_edge) begin
        check("rf_we_reset", 64'(bus.rf_we), 64'(0));
        check("rf_port_reset", 64'({bus.rf_wreg, bus.rf_wdata}), 64'(0));
        last_exp = '0;
      end else if (bus.rf_we) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rf_write_unexpected: got reg %0d data 0x%0h expected no write at %0t",
                   bus.rf_wreg, bus.rf_wdata, $time);
        end else begin
          last_exp = exp_q.pop_front();
          check("rf_write", 64'({bus.rf_wreg, bus.rf_wdata}), 64'(last_exp));
        end
      end else begin
        check("rf_hold", 64'({bus.rf_wreg, bus.rf_wdata}), 64'(last_exp));
      end
    end
  end

  // ---------------- driver ----------------
  // One cycle of stimulus. A stalled writeback and an unaccepted
  // long-latency offer both keep their previous values.
  task automatic step(input bit r,
                      input bit wv, input logic [REG_W-1:0] wr, input logic [DATA_W-1:0] wd,
                      input bit lv, input logic [REG_W-1:0] lr, input logic [DATA_W-1:0] ld);
    @(posedge clk);
    #1;
    rst = r;
    if (!last_stall) begin
      bus.wb_wback = wv;
      bus.wb_wreg  = wr;
      bus.wb_wdata = wd;
    end
    if (!bus.ll_valid || last_acc) begin
      bus.ll_valid = lv;
      bus.ll_wreg  = lr;
      bus.ll_wdata = ld;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  initial begin
    // Reset held for two edges with both sources requesting.
    rst          = 1'b0;
    bus.wb_wback = 1'b1;
    bus.wb_wreg  = REG_W'(3);
    bus.wb_wdata = 32'h1111_1111;
    bus.ll_valid = 1'b1;
    bus.ll_wreg  = REG_W'(7);
    bus.ll_wdata = 32'h2222_2222;
    repeat (2) @(posedge clk);
    #1;
    rst          = 1'b1;
    bus.wb_wback = 1'b0;
    bus.ll_valid = 1'b0;
    idle(2);

    // Writeback only.
    step(1'b1, 1'b1, REG_W'(5), 32'hDEAD_BEEF, 1'b0, '0, '0);
    idle(2);

    // Long-latency result into an idle pipeline.
    step(1'b1, 1'b0, '0, '0, 1'b1, REG_W'(7), 32'h0000_1234);
    idle(4);

    // Starvation: continuous writeback to reg 3 forces reg 9 through.
    step(1'b1, 1'b1, REG_W'(3), $urandom, 1'b1, REG_W'(9), 32'h9999_0009);
    for (int i = 0; i < 9; i++) step(1'b1, 1'b1, REG_W'(3), $urandom, 1'b0, '0, '0);
    idle(3);

    // Full FIFO under continuous writeback: third offer waits for space.
    step(1'b1, 1'b1, REG_W'(3), $urandom, 1'b1, REG_W'(1), 32'hAAAA_0001);
    step(1'b1, 1'b1, REG_W'(3), $urandom, 1'b1, REG_W'(2), 32'hAAAA_0002);
    step(1'b1, 1'b1, REG_W'(3), $urandom, 1'b1, REG_W'(4), 32'hAAAA_0004);
    for (int i = 0; i < 24; i++) step(1'b1, 1'b1, REG_W'(3), $urandom, 1'b0, '0, '0);
    idle(4);

    // Writes to x0 from either source.
    step(1'b1, 1'b1, '0, 32'h0BAD_0BAD, 1'b0, '0, '0);
    step(1'b1, 1'b0, '0, '0, 1'b1, '0, 32'h0BAD_0001);
    idle(3);

    // Random traffic with one mid-run reset.
    for (int i = 0; i < 600; i++) begin
      step(!(i == 300 || i == 301),
           ($urandom_range(0, 3) != 0), REG_W'($urandom_range(0, 31)), $urandom,
           ($urandom_range(0, 2) == 0), REG_W'($urandom_range(0, 31)), $urandom);
    end
    idle(12);

    check("exp_q_drained", 64'(exp_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Arbitrates the single register-file write port between the in-order pipeline's writeback stage and an out-of-band long-latency unit (multiply/divide, miss-return loads). Long-latency results are buffered in a small FIFO and normally written in cycles the pipeline leaves idle. An age counter forces the oldest buffered result through after a bounded wait, stalling the pipeline's writeback for one cycle. It sits between the writeback stage output and the register file.

## Interface
Parameters:
- DATA_W, 32, write data width
- REG_W, 5, register index width
- DEPTH, 2, long-latency FIFO entries (≥1)
- MAX_WAIT, 4, cycles the FIFO head may wait before forced grant (≥1)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset; one clock, reset is synchronous and active-low (rst==0 resets)
- wb_wback  in  1  pipeline writeback request
- wb_wreg  in  REG_W  pipeline destination register
- wb_wdata  in  DATA_W  pipeline write data
- wb_stall  out  1  combinational; pipeline must hold its wb_* inputs for the next cycle
- ll_valid  in  1  long-latency result valid
- ll_ready  out  1  combinational; FIFO can accept
- ll_wreg  in  REG_W  long-latency destination register
- ll_wdata  in  DATA_W  long-latency data
- rf_we  out  1  registered register-file write enable
- rf_wreg  out  REG_W  registered write index
- rf_wdata  out  DATA_W  registered write data
- ll_pending  out  clog2(DEPTH+1)  current FIFO occupancy

## Operation
- wb_eff = wb_wback && wb_wreg != 0. Pipeline writes to x0 are dropped, never granted, never stalled.
- ll_ready = rst && (count < DEPTH). Accept on ll_valid && ll_ready. If ll_wreg == 0, accept and discard (no enqueue).
- Grant decision each cycle (combinational, from current state):
  - FIFO non-empty and (age >= MAX_WAIT or !wb_eff): grant LL. Pop head; rf_we<=1, rf_wreg/rf_wdata<=head. wb_stall = wb_eff.
  - else if wb_eff: grant WB. rf_we<=1, rf_wreg/rf_wdata<=wb_*. wb_stall=0.
  - else: rf_we<=0; rf_wreg/rf_wdata hold their previous values.
- Age counter tracks the current head only. It is 0 when the FIFO is empty or the head is popped. It increments each cycle the head is present but not granted, saturating at MAX_WAIT.
- Push and pop in the same cycle are legal. The count is unchanged, and the pushed entry goes behind the remaining entries. A push into an empty FIFO is not eligible for grant in the same cycle.
- Write ordering between sources to the same register is not enforced here. The upstream scoreboard prevents it.
- Reset (rst==0): FIFO emptied, age=0, rf_we=0, rf_wreg=0, rf_wdata=0, ll_pending=0. ll_ready=0 and wb_stall=0 while in reset. Reset mid-operation discards buffered entries.

## Timing
- WB path latency: request in cycle t, rf_we visible in t+1.
- LL path latency, idle pipeline: accepted at edge ending cycle t, granted in t+1, rf_we visible in t+2.
- Under continuous wb_eff: the head is forced in the cycle where age reaches MAX_WAIT, i.e. MAX_WAIT cycles after it became head. wb_stall is high exactly that cycle.
- Back-to-back forced grants: after a pop, the new head restarts at age 0. The pipeline therefore gets at least MAX_WAIT grants between stalls.
- At most one register-file write per cycle. ll_ready goes low the cycle after occupancy reaches DEPTH.

## Test plan
- Reset: rst=0 for 2 cycles with ll_valid=1, wb_wback=1 -> rf_we=0, ll_ready=0, wb_stall=0, ll_pending=0. After release, ll_ready=1 and nothing was enqueued.
- WB only: wb_wback=1, wb_wreg=5, wb_wdata=0xDEADBEEF in cycle t -> rf_we=1, rf_wreg=5, rf_wdata=0xDEADBEEF in t+1; wb_stall=0 throughout.
- LL in idle slot: ll_valid=1, ll_wreg=7, ll_wdata=0x1234 accepted cycle t, wb idle -> rf_we=1, rf_wreg=7, rf_wdata=0x1234 in t+2; ll_pending returns to 0.
- Starvation (MAX_WAIT=4): LL reg 9 accepted cycle t, wb_wback=1 reg 3 every cycle -> reg 3 written in t+1..t+5. wb_stall=1 only in t+5. Reg 9 written in t+6, reg 3 resumes in t+7.
- Full (DEPTH=2, MAX_WAIT=15): three LL pushes (regs 1, 2, 4) with continuous wb_eff -> ll_ready=0 after the second accept. The third stays held until regs 1 and 2 are forced out in order. Then reg 4 is accepted with no data loss.
- x0: wb_wreg=0 with wb_wback=1 -> rf_we=0, wb_stall=0. ll_wreg=0 with ll_valid=1 -> accepted, ll_pending stays 0, no write.
